// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: radix-2 multi-cycle mult/multu/div/divu unit with HI/LO registers and stall control.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies finish early once the remaining multiplier bits are zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               res_neg, rem_neg, dbz_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     add_sum, rem_sh, rem_sub;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, a_back;
    logic               is_div, sa, sb;
    assign is_div  = op_q[1];
    assign sa      = !op[0] && a[WIDTH-1];
    assign sb      = !op[0] && b[WIDTH-1];
    assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : {WIDTH{1'b0}})};
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
    assign q_bit   = rem_sh >= {1'b0, mag_b};
    assign rem_sub = q_bit ? rem_sh - {1'b0, mag_b} : rem_sh;
    assign prod    = res_neg ? -acc : acc;
    assign quo     = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem     = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign a_back  = rem_neg ? -mag_a : mag_a;
    assign stall   = (start && state == IDLE) || (state != IDLE && state != DONE);
    // Sequencer: operand capture, iteration datapath, sign fix-up and HI/LO update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_q        <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            dbz_q       <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_hi) hi <= wdata;
                    if (wr_lo) lo <= wdata;
                    if (start) begin
                        op_q    <= op;
                        mag_a   <= sa ? -a : a;
                        mag_b   <= sb ? -b : b;
                        res_neg <= sa ^ sb;
                        rem_neg <= sa;
                        busy    <= 1'b1;
                        state   <= PREP;
                    end
                end
                PREP: begin
                    acc <= '0;
                    cnt <= CW'(WIDTH - 1);
                    if (is_div && mag_b == '0) begin
                        dbz_q <= 1'b1;
                        state <= FIX;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (EARLY && !is_div && mag_b == '0) begin
                        acc   <= acc >> ((CW+1)'(cnt) + (CW+1)'(1));
                        state <= FIX;
                    end else begin
                        if (is_div) begin
                            acc   <= {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], q_bit};
                            mag_a <= mag_a << 1;
                        end else begin
                            acc   <= {add_sum, acc[WIDTH-1:1]};
                            mag_b <= mag_b >> 1;
                        end
                        if (cnt == '0) state <= FIX;
                        else cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (dbz_q) begin
                        hi          <= a_back;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        {hi, lo} <= prod;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    div_by_zero <= 1'b0;
                    dbz_q       <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo;
    int          n_cmp = 0, n_fail = 0, cyc = 0;
    logic [31:0] last_hi, last_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          t0;
    } exp_t;
    exp_t q[$];

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic; latency from the documented cycle counts
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint px, py, qq, rr;
        logic [63:0] p;
        logic [31:0] mag;
        int len;
        px = longint'($signed(x));
        py = longint'($signed(y));
        e.dbz = 1'b0;
        e.lat = 34;
        e.t0  = 0;
        case (o)
            2'd0: begin p = px * py; {e.hi, e.lo} = p; end
            2'd1: begin p = {32'b0, x} * {32'b0, y}; {e.hi, e.lo} = p; end
            2'd2: begin
                if (y == 0) begin e.hi = x; e.lo = '1; e.dbz = 1'b1; e.lat = 2; end
                else begin qq = px / py; rr = px % py; e.lo = qq[31:0]; e.hi = rr[31:0]; end
            end
            default: begin
                if (y == 0) begin e.hi = x; e.lo = '1; e.dbz = 1'b1; e.lat = 2; end
                else begin e.lo = x / y; e.hi = x % y; end
            end
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            mag = (o == 2'd0 && y[31]) ? -y : y;
            len = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
            e.lat = (3 + len < 34) ? 3 + len : 34;
        end
`else
        mag = '0;
        len = 0;
`endif
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        check("idle_wait", busy, 0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit intf);
        exp_t e;
        wait_idle();
        e = model(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        #1 check("stall_on_start", stall, 1);
        @(posedge clk);
        #1 start = 1'b0;
        e.t0 = cyc;
        q.push_back(e);
        for (int j = 0; j < e.lat; j++) begin
            check("stall_in_flight", stall, 1);
            check("busy_in_flight", busy, 1);
            if (intf && j == 5) begin
                start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
                wr_lo = 1'b1; wdata = 32'hAA;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            wr_lo = 1'b0;
        end
        check("stall_in_done", stall, 0);
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("div_by_zero", div_by_zero, e.dbz);
                check("latency", cyc - e.t0, e.lat);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x, y;
        int n;
        #2;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk) rst = 1'b1;
        // Write alongside start, then abort with reset mid-iteration
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 7; b = 9; wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        check("wr_with_start_hi", hi, 32'hDEADBEEF);
        check("wr_with_start_lo", lo, 32'hDEADBEEF);
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_resume", busy, 0);
        // Directed operations
        do_op(2'd0, 32'hFFFFFFFE, 32'd3, 0);
        do_op(2'd2, 32'hFFFFFFF9, 32'd2, 0);
        do_op(2'd3, 32'hFFFFFFFF, 32'h10, 1);
        do_op(2'd2, 32'h1234, 32'd0, 0);
        do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        do_op(2'd0, 32'd5, 32'd0, 0);
        do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op(2'd3, 32'd0, 32'd0, 0);
        // mtlo / mthi in IDLE, and value retention
        wait_idle();
        check("hold_hi", hi, last_hi);
        check("hold_lo", lo, last_lo);
        @(negedge clk) wr_lo = 1'b1; wdata = 32'h55;
        @(posedge clk);
        #1 wr_lo = 1'b0;
        check("mtlo", lo, 32'h55);
        check("mtlo_keeps_hi", hi, last_hi);
        @(negedge clk) wr_hi = 1'b1; wdata = 32'h66;
        @(posedge clk);
        #1 wr_hi = 1'b0;
        check("mthi", hi, 32'h66);
        check("mthi_keeps_lo", lo, 32'h55);
        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = $urandom_range(1, 15);
                2:       y = 32'hFFFFFFFF;
                3:       y = $urandom >> $urandom_range(0, 31);
                default: y = $urandom;
            endcase
            do_op(2'($urandom_range(0, 3)), x, y, $urandom_range(0, 3) == 0);
        end
        n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
